// File: rtl/pixel_mem_dp_pipe.sv
// pixel_mem_dp_pipe: true-dual-port pixel frame memory with per-lane write
// masks, 1/2-cycle registered reads, read-during-write mode select and a
// hardware clear sequencer that fills the array with INIT_VAL.

// Per-port read return pipeline: one valid pulse per accepted access; rdata holds between pulses.
module pixel_mem_rd_pipe #(
  parameter int WIDTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             rvalid_o,
  output logic [WIDTH-1:0] rdata_o
);
  logic             vld1_q;
  logic [WIDTH-1:0] dat1_q;

  // First stage captures the word read at the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
      dat1_q <= '0;
    end else begin
      vld1_q <= acc_i;
      if (acc_i) dat1_q <= data_i;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign rvalid_o = vld1_q;
    assign rdata_o  = dat1_q;
  end else begin : g_lat2
    logic             vld2_q;
    logic [WIDTH-1:0] dat2_q;

    // Second stage delays the return by one more cycle; in-flight data survives a clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld2_q <= 1'b0;
        dat2_q <= '0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) dat2_q <= dat1_q;
      end
    end

    assign rvalid_o = vld2_q;
    assign rdata_o  = dat2_q;
  end
endmodule

module pixel_mem_dp_pipe #(
  parameter int               DEPTH    = 1024,
  parameter int               WIDTH    = 16,
  parameter int               LANES    = 2,
  parameter int               RD_LAT   = 1,
  parameter int               RDW_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_req,
  output logic             busy,
  input  logic             a_en,
  input  logic             a_we,
  input  logic [LANES-1:0] a_be,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic [WIDTH-1:0] a_rdata,
  output logic             a_rvalid,
  input  logic             b_en,
  input  logic             b_we,
  input  logic [LANES-1:0] b_be,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic [WIDTH-1:0] b_rdata,
  output logic             b_rvalid,
  output logic             collision
);
  localparam int          LW      = WIDTH / LANES;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            busy_q, busy_d;
  logic            collision_q;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             a_acc, b_acc, a_rng, b_rng, a_wr, b_wr, same_addr;
  logic [WIDTH-1:0] a_old, b_old, a_new, b_new, a_rd, b_rd;

  // Ports are locked out for the whole sweep; out-of-range addresses never touch the array.
  assign a_acc     = a_en & ~busy_q;
  assign b_acc     = b_en & ~busy_q;
  assign a_rng     = ({1'b0, a_addr} < DEPTH_W);
  assign b_rng     = ({1'b0, b_addr} < DEPTH_W);
  assign a_wr      = a_acc & a_we & a_rng;
  assign b_wr      = b_acc & b_we & b_rng;
  assign same_addr = (a_addr == b_addr);
  assign a_old     = a_rng ? mem_q[a_addr] : '0;
  assign b_old     = b_rng ? mem_q[b_addr] : '0;

  // Word as it will look after this edge at each port's address; A owns overlapping lanes.
  always_comb begin
    a_new = a_old;
    b_new = b_old;
    for (int l = 0; l < LANES; l++) begin
      if (a_wr && a_be[l])                   a_new[l*LW +: LW] = a_wdata[l*LW +: LW];
      else if (b_wr && b_be[l] && same_addr) a_new[l*LW +: LW] = b_wdata[l*LW +: LW];
      if (a_wr && a_be[l] && same_addr)      b_new[l*LW +: LW] = a_wdata[l*LW +: LW];
      else if (b_wr && b_be[l])              b_new[l*LW +: LW] = b_wdata[l*LW +: LW];
    end
  end

  // A writer sees its own result only in write-first mode; a pure reader always sees the old word.
  assign a_rd = (RDW_MODE != 0 && a_wr) ? a_new : a_old;
  assign b_rd = (RDW_MODE != 0 && b_wr) ? b_new : b_old;

  // Array update: sweep has priority; B lanes go first so A overwrites on overlap.
  always_ff @(posedge clk) begin
    if (busy_q) begin
      mem_q[clr_addr_q] <= INIT_VAL;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (b_wr && b_be[l]) mem_q[b_addr][l*LW +: LW] <= b_wdata[l*LW +: LW];
        if (a_wr && a_be[l]) mem_q[a_addr][l*LW +: LW] <= a_wdata[l*LW +: LW];
      end
    end
  end

  // Clear sequencer next state: one word per cycle, restart only from READY.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d    = S_READY;
          clr_addr_d = '0;
        end
      end
      S_READY: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
    busy_d = (state_d == S_CLEAR);
  end

  // Sequencer state; reset lands in CLEAR so every power-up starts with a full sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  // Flag both ports writing the same lane of the same word at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision_q <= 1'b0;
    else        collision_q <= a_wr & b_wr & same_addr & (|(a_be & b_be));
  end

  pixel_mem_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_rd_a (
    .clk(clk), .rst_n(rst_n), .acc_i(a_acc), .data_i(a_rd),
    .rvalid_o(a_rvalid), .rdata_o(a_rdata)
  );

  pixel_mem_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_rd_b (
    .clk(clk), .rst_n(rst_n), .acc_i(b_acc), .data_i(b_rd),
    .rvalid_o(b_rvalid), .rdata_o(b_rdata)
  );

  assign busy      = busy_q;
  assign collision = collision_q;
endmodule
